hqm_aw_pipe_rate_limit_shaper: RTL and testbench

Gates the input valid bits of a pipeline with three independent throttles:
- pipeline-occupancy mask (combinational);
- minimum issue gap (counter);
- token-bucket issue budget (refill counter plus token counter).

It sits at the head of a pipeline, between the issuing arbiter and pipe stage 0. It also keeps a saturating stall counter for performance monitoring.

---
 rtl/hqm_aw_pipe_rate_limit_shaper_pkg.sv | 19 +
 rtl/hqm_aw_pipe_rate_limit_shaper_if.sv | 17 +
 rtl/hqm_aw_pipe_rate_limit_shaper_tokens.sv | 47 ++++
 rtl/hqm_aw_pipe_rate_limit_shaper.sv | 76 +++++++
 tb/tb_hqm_aw_pipe_rate_limit_shaper.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/hqm_aw_pipe_rate_limit_shaper_pkg.sv
// Shared defaults and helpers for the pipeline rate-limit shaper.
// Imported by the interface, the token bucket and the top level.
package hqm_aw_pipe_rate_limit_shaper_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_DEPTH = 1;
    localparam int DEF_GAPW  = 4;
    localparam int DEF_TOKW  = 4;
    localparam int DEF_PERW  = 8;
    localparam int DEF_STLW  = 16;

    // Increment a counter of width w (w <= 32), holding at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
        logic [31:0] max_val;
        max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/hqm_aw_pipe_rate_limit_shaper_if.sv
// Valid-vector bus between the issuing arbiter and pipe stage 0.
// The master drives candidates and stage valids; the shaper returns gated valids.
interface hqm_aw_pipe_rate_limit_shaper_if
    import hqm_aw_pipe_rate_limit_shaper_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    logic [WIDTH-1:0] v_in;
    logic [DEPTH-1:0] pipe_v;
    logic [WIDTH-1:0] v_out;
    logic             allow;

    modport master (output v_in, output pipe_v, input v_out, input allow);
    modport slave  (input v_in, input pipe_v, output v_out, output allow);

endinterface

// File: rtl/hqm_aw_pipe_rate_limit_shaper_tokens.sv
// Token-bucket issue budget: a refill period counter plus a clamped token counter.
// Disabled (tokens held at 0, always open) when cfg_tok_max is 0.
module hqm_aw_pipe_rate_limit_shaper_tokens
    import hqm_aw_pipe_rate_limit_shaper_pkg::*;
#(
    parameter int TOKW = DEF_TOKW,
    parameter int PERW = DEF_PERW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [TOKW-1:0] cfg_tok_max,
    input  logic [PERW-1:0] cfg_tok_period,
    input  logic            issue,
    output logic [TOKW-1:0] tokens,
    output logic            allow_tok
);

    logic [PERW-1:0] per_cnt;
    logic            enabled;
    logic            refill;
    logic            consume;
    logic [TOKW:0]   tok_sum;
    logic [TOKW-1:0] tok_next;

    assign enabled   = |cfg_tok_max;
    assign refill    = (per_cnt == cfg_tok_period);
    assign consume   = issue & enabled;
    assign allow_tok = ~enabled | (|tokens);

    // One extra bit of headroom so a refill at capacity clamps instead of wrapping.
    always_comb begin
        tok_sum  = {1'b0, tokens} + {{TOKW{1'b0}}, refill} - {{TOKW{1'b0}}, consume};
        tok_next = (tok_sum > {1'b0, cfg_tok_max}) ? cfg_tok_max : tok_sum[TOKW-1:0];
    end

    // Wrap on >= so a shortened period never strands the counter above the new limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt <= '0;
            tokens  <= '0;
        end else begin
            per_cnt <= (per_cnt >= cfg_tok_period) ? '0 : per_cnt + PERW'(1);
            tokens  <= tok_next;
        end
    end

endmodule

// File: rtl/hqm_aw_pipe_rate_limit_shaper.sv
// Head-of-pipe issue shaper: gates candidate valids with occupancy mask, minimum
// issue gap and token-bucket throttles, and counts stalled cycles.
module hqm_aw_pipe_rate_limit_shaper
    import hqm_aw_pipe_rate_limit_shaper_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int GAPW  = DEF_GAPW,
    parameter int TOKW  = DEF_TOKW,
    parameter int PERW  = DEF_PERW,
    parameter int STLW  = DEF_STLW
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DEPTH-1:0]                 cfg_mask,
    input  logic [GAPW-1:0]                  cfg_gap,
    input  logic [TOKW-1:0]                  cfg_tok_max,
    input  logic [PERW-1:0]                  cfg_tok_period,
    hqm_aw_pipe_rate_limit_shaper_if.slave   bus,
    output logic [TOKW-1:0]                  tokens,
    output logic [STLW-1:0]                  stall_cnt,
    input  logic                             stall_clr
);

    logic [GAPW-1:0] gap_cnt;
    logic            allow_mask;
    logic            allow_gap;
    logic            allow_tok;
    logic            allow_all;
    logic            issue;
    logic            any_v;

    assign allow_mask = ~|(cfg_mask & bus.pipe_v);
    assign allow_gap  = (gap_cnt == '0);
    assign allow_all  = allow_mask & allow_gap & allow_tok;
    assign any_v      = |bus.v_in;
    assign issue      = allow_all & any_v;

    assign bus.allow  = allow_all;
    assign bus.v_out  = bus.v_in & {WIDTH{allow_all}};

    hqm_aw_pipe_rate_limit_shaper_tokens #(
        .TOKW (TOKW),
        .PERW (PERW)
    ) u_tokens (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_tok_max    (cfg_tok_max),
        .cfg_tok_period (cfg_tok_period),
        .issue          (issue),
        .tokens         (tokens),
        .allow_tok      (allow_tok)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (issue) begin
            gap_cnt <= cfg_gap;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAPW'(1);
        end
    end

    // Clear wins over a simultaneous blocked cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (any_v && !allow_all) begin
            stall_cnt <= STLW'(sat_inc(32'(stall_cnt), STLW));
        end
    end

endmodule

// File: tb/tb_hqm_aw_pipe_rate_limit_shaper.sv
// Scoreboard bench for the rate-limit shaper: directed cycles push hand-computed
// expectations, and a negedge monitor pops and compares them.
module tb_hqm_aw_pipe_rate_limit_shaper;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int GAPW  = 4;
    localparam int TOKW  = 4;
    localparam int PERW  = 8;
    localparam int STLW  = 4;

    typedef struct {
        string      tag;
        logic [3:0] chk;
        logic [1:0] ev;
        logic       ea;
        logic [3:0] et;
        logic [3:0] es;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DEPTH-1:0] cfg_mask;
    logic [GAPW-1:0]  cfg_gap;
    logic [TOKW-1:0]  cfg_tok_max;
    logic [PERW-1:0]  cfg_tok_period;
    logic [TOKW-1:0]  tokens;
    logic [STLW-1:0]  stall_cnt;
    logic             stall_clr;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int gap_stall [9]  = '{0, 0, 1, 2, 3, 3, 4, 5, 6};
    int tok_run   [16] = '{2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int tok_stall [16] = '{0, 0, 0, 1, 2, 3, 3, 4, 5, 6, 7, 7, 8, 9, 10, 11};

    hqm_aw_pipe_rate_limit_shaper_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    hqm_aw_pipe_rate_limit_shaper #(
        .WIDTH (WIDTH), .DEPTH (DEPTH), .GAPW (GAPW),
        .TOKW  (TOKW),  .PERW  (PERW),  .STLW (STLW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_mask       (cfg_mask),
        .cfg_gap        (cfg_gap),
        .cfg_tok_max    (cfg_tok_max),
        .cfg_tok_period (cfg_tok_period),
        .bus            (bus.slave),
        .tokens         (tokens),
        .stall_cnt      (stall_cnt),
        .stall_clr      (stall_clr)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue what the outputs must show this cycle, then advance.
    task automatic applyStimulus(input logic rstn, input logic [3:0] pv, input logic [1:0] vin,
                                 input logic clr, input logic [3:0] chk, input logic [1:0] ev,
                                 input logic ea, input logic [3:0] et, input logic [3:0] es,
                                 input string tag);
        exp_t e;
        rst_n      = rstn;
        bus.pipe_v = pv;
        bus.v_in   = vin;
        stall_clr  = clr;
        if (chk != 4'd0) begin
            e.tag = tag; e.chk = chk; e.ev = ev; e.ea = ea; e.et = et; e.es = es;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.chk[0]) begin
            checks++;
            if (bus.v_out !== e.ev) begin
                errors++;
                $display("[TB] FAIL %s.v_out: got %b expected %b", e.tag, bus.v_out, e.ev);
            end
        end
        if (e.chk[1]) begin
            checks++;
            if (bus.allow !== e.ea) begin
                errors++;
                $display("[TB] FAIL %s.allow: got %b expected %b", e.tag, bus.allow, e.ea);
            end
        end
        if (e.chk[2]) begin
            checks++;
            if (tokens !== e.et) begin
                errors++;
                $display("[TB] FAIL %s.tokens: got %0d expected %0d", e.tag, tokens, e.et);
            end
        end
        if (e.chk[3]) begin
            checks++;
            if (stall_cnt !== e.es) begin
                errors++;
                $display("[TB] FAIL %s.stall_cnt: got %0d expected %0d", e.tag, stall_cnt, e.es);
            end
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        logic       ea;
        logic [3:0] et;
        rst_n = 1'b0; cfg_mask = '0; cfg_gap = '0; cfg_tok_max = '0; cfg_tok_period = '0;
        stall_clr = 1'b0; bus.v_in = '0; bus.pipe_v = '0;
        @(posedge clk);
        #1;

        // Reset state and the occupancy mask.
        applyStimulus(0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 0, 0, 0, "rst");
        applyStimulus(1, 4'h0, 2'b00, 0, 4'hF, 2'b00, 1, 0, 0, "reset_state");
        cfg_mask = 4'b0100;
        applyStimulus(1, 4'b0100, 2'b01, 0, 4'hF, 2'b00, 0, 0, 0, "mask_block0");
        applyStimulus(1, 4'b0100, 2'b01, 0, 4'hF, 2'b00, 0, 0, 1, "mask_block1");
        applyStimulus(1, 4'b0100, 2'b01, 0, 4'hF, 2'b00, 0, 0, 2, "mask_block2");
        applyStimulus(1, 4'b1011, 2'b01, 0, 4'hF, 2'b01, 1, 0, 3, "mask_pass");
        applyStimulus(1, 4'b1011, 2'b11, 0, 4'hF, 2'b11, 1, 0, 3, "mask_pass_w2");
        applyStimulus(1, 4'b0000, 2'b00, 1, 4'hF, 2'b00, 1, 0, 3, "clr_req");
        applyStimulus(1, 4'b0000, 2'b00, 0, 4'hF, 2'b00, 1, 0, 0, "clr_done");
        cfg_mask = 4'b1111;
        applyStimulus(1, 4'b0000, 2'b01, 0, 4'hF, 2'b01, 1, 0, 0, "mask_all_empty");
        applyStimulus(1, 4'b1000, 2'b01, 0, 4'hF, 2'b00, 0, 0, 0, "mask_all_busy");
        applyStimulus(1, 4'b0000, 2'b00, 0, 4'hF, 2'b00, 1, 0, 1, "mask_all_after");

        // Minimum gap of 3: issues every fourth cycle.
        cfg_mask = '0; cfg_gap = 4'd3;
        applyStimulus(0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 0, 0, 0, "rst");
        for (int k = 0; k < 9; k++) begin
            ea = (k % 4 == 0);
            applyStimulus(1, 4'h0, 2'b01, 0, 4'hF, ea ? 2'b01 : 2'b00, ea, 0,
                          4'(gap_stall[k]), $sformatf("gap_k%0d", k));
        end

        // Token bucket: cap 2, one token every 5 cycles.
        cfg_gap = '0; cfg_tok_max = 4'd2; cfg_tok_period = 8'd4;
        applyStimulus(0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 0, 0, 0, "rst");
        for (int k = 0; k < 20; k++) begin
            et = (k < 5) ? 4'd0 : (k < 10) ? 4'd1 : 4'd2;
            applyStimulus(1, 4'h0, 2'b00, 0, 4'hF, 2'b00, et != 0, et, 0,
                          $sformatf("tok_fill_k%0d", k));
        end
        for (int k = 0; k < 16; k++) begin
            ea = (tok_run[k] != 0);
            applyStimulus(1, 4'h0, 2'b01, 0, 4'hF, ea ? 2'b01 : 2'b00, ea, 4'(tok_run[k]),
                          4'(tok_stall[k]), $sformatf("tok_run_k%0d", k + 20));
        end

        // Refill and consume together, then disable the bucket with a token left.
        applyStimulus(0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 0, 0, 0, "rst");
        for (int k = 0; k < 9; k++)
            applyStimulus(1, 4'h0, 2'b00, 0, 4'h0, 2'b00, 0, 0, 0, "idle");
        applyStimulus(1, 4'h0, 2'b01, 0, 4'hF, 2'b01, 1, 1, 0, "refill_consume");
        applyStimulus(1, 4'h0, 2'b00, 0, 4'hF, 2'b00, 1, 1, 0, "tok_hold");
        cfg_tok_max = 4'd0;
        applyStimulus(1, 4'h0, 2'b01, 0, 4'hF, 2'b01, 1, 1, 0, "tok_off_same_cycle");
        applyStimulus(1, 4'h0, 2'b01, 0, 4'hF, 2'b01, 1, 0, 0, "tok_off_clamped");
        applyStimulus(1, 4'h0, 2'b01, 0, 4'hF, 2'b01, 1, 0, 0, "tok_off_every_cycle");

        // Build up gap, token and stall state, then reset in the middle of it.
        cfg_tok_max = 4'd3; cfg_tok_period = 8'd0; cfg_mask = 4'b0001;
        applyStimulus(0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 0, 0, 0, "rst");
        applyStimulus(1, 4'h0, 2'b00, 0, 4'hF, 2'b00, 0, 0, 0, "tok3_k0");
        applyStimulus(1, 4'h0, 2'b00, 0, 4'h4, 2'b00, 0, 1, 0, "tok3_k1");
        applyStimulus(1, 4'h0, 2'b00, 0, 4'h4, 2'b00, 0, 2, 0, "tok3_k2");
        for (int k = 3; k < 9; k++)
            applyStimulus(1, 4'b0001, 2'b01, 0, 4'hC, 2'b00, 0, 3, 4'(k - 3),
                          $sformatf("tok3_blk_k%0d", k));
        cfg_mask = '0; cfg_gap = 4'd3;
        applyStimulus(1, 4'b0001, 2'b01, 0, 4'hF, 2'b01, 1, 3, 6, "mid_issue");
        applyStimulus(1, 4'b0001, 2'b01, 0, 4'hF, 2'b00, 0, 3, 6, "mid_gap");
        applyStimulus(0, 4'b0001, 2'b01, 0, 4'hF, 2'b00, 0, 3, 7, "pre_reset");
        applyStimulus(1, 4'b0001, 2'b01, 0, 4'hF, 2'b00, 0, 0, 0, "post_reset_blocked");
        applyStimulus(1, 4'b0001, 2'b01, 0, 4'hF, 2'b01, 1, 1, 1, "first_refill_issue");

        // Stall counter saturation and clear priority.
        cfg_gap = '0; cfg_tok_max = '0; cfg_mask = 4'b0001;
        applyStimulus(0, 4'h0, 2'b00, 0, 4'h0, 2'b00, 0, 0, 0, "rst");
        for (int k = 0; k < 20; k++)
            applyStimulus(1, 4'b0001, 2'b01, 0, 4'hF, 2'b00, 0, 0, (k > 15) ? 4'd15 : 4'(k),
                          $sformatf("sat_k%0d", k));
        applyStimulus(1, 4'b0001, 2'b01, 1, 4'hF, 2'b00, 0, 0, 15, "clr_while_blocked");
        applyStimulus(1, 4'b0001, 2'b01, 0, 4'hF, 2'b00, 0, 0, 0, "clr_wins");
        applyStimulus(1, 4'b0001, 2'b01, 0, 4'hF, 2'b00, 0, 0, 1, "count_resumes");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
